// File: rtl/mc_mem_pkg.sv
// rtl/mc_mem_pkg.sv - shared types and constants for the memory responder
package mc_mem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/mc_mem_array.sv
// rtl/mc_mem_array.sv - single-port word array, synchronous write, registered read
module mc_mem_array #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

  // One access per enabled edge: write the word, or capture it into the read register
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mc_mem_resp.sv
// rtl/mc_mem_resp.sv - wait-state memory responder; MC_MEM_RESP_ERR_EN adds address checking and o_err
module mc_mem_resp
  import mc_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       i_addr,
  input  logic [WORD_W-1:0] i_WriteData,
  output logic [WORD_W-1:0] o_MemData,
  output logic              o_ready,
  output logic              o_busy
`ifdef MC_MEM_RESP_ERR_EN
  , output logic            o_err
`endif
);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                wr_q;
  logic                err_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                err_in;
  logic                acc_en;
  logic                have_data;
  logic [WORD_W-1:0]   rdata;

`ifdef MC_MEM_RESP_ERR_EN
  assign err_in = (i_addr[1:0] != 2'b00) || (i_addr[31:ADDR_W+2] != '0);
  assign o_err  = o_ready & err_q;
`else
  assign err_in = 1'b0;
  wire unused_addr_bits = &{1'b0, i_addr[31:ADDR_W+2], i_addr[1:0]};
`endif

  // Request FSM: latch the request in IDLE, count wait states, then one ACCESS cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      o_ready <= 1'b0;
      o_busy  <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_ready <= 1'b0;
          if (MemRead || MemWrite) begin
            // A write wins when both strobes are high
            wr_q    <= MemWrite;
            err_q   <= err_in;
            idx_q   <= i_addr[ADDR_W+1:2];
            wdata_q <= i_WriteData;
            o_busy  <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES);
            end else begin
              state   <= ACCESS;
              o_ready <= 1'b1;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state   <= ACCESS;
            o_ready <= 1'b1;
          end
        end
        ACCESS: begin
          state   <= IDLE;
          cnt     <= '0;
          o_ready <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          o_ready <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array touched only in ACCESS, and never for a flagged address
  assign acc_en = (state == ACCESS) && !err_q;

  // Read data reads as zero after reset until the first read completes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      have_data <= 1'b0;
    end else if (acc_en && !wr_q) begin
      have_data <= 1'b1;
    end
  end

  assign o_MemData = have_data ? rdata : '0;

  mc_mem_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_array (
    .clk   (i_clk),
    .en    (acc_en),
    .we    (wr_q),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

endmodule
